cafe_dispenser: RTL and testbench
=================================

Name: cafe_dispenser

Overview:
- Dispensing-side controller for the cafe vending path. It consumes the level-valued coffee/soup grant outputs of the cafe decision logic and drives the physical valves.
- Sequential: latches one grant, waits for a cup, opens the matching valve for a fixed number of cycles, then reports completion.
- It re-arms only after both grants drop, so a held request never double-dispenses.
- Sits between the cafe selection logic and the valve drivers/status panel.

Parameters:
- COFFEE_CYCLES, 8, valve-open duration for coffee in clk cycles (legal range 1..2^CNT_W-1)
- SOUP_CYCLES, 12, valve-open duration for soup in clk cycles (legal range 1..2^CNT_W-1)
- CUP_TIMEOUT, 16, cycles to wait in WAIT_CUP for cup_present before aborting (legal range 1..2^CNT_W-1)
- CNT_W, 8, width of the shared down-counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- coffee  in  1  coffee grant from the selection logic (level)
- soup  in  1  soup grant from the selection logic (level)
- cup_present  in  1  cup sensor, 1 = cup under spout
- busy  out  1  1 in any state other than IDLE
- valve_coffee  out  1  coffee valve drive
- valve_soup  out  1  soup valve drive
- done  out  1  one-cycle pulse on successful serve
- error  out  1  one-cycle pulse on cup timeout or cup removal during pour
- served_count  out  8  successful serves since reset, saturates at 255

Behaviour:
- Reset: on a rising clk edge with rst=1, the state goes to IDLE. busy, valve_coffee, valve_soup, done and error all go to 0. served_count, the counter and the product latch all clear. rst overrides all other inputs, including mid-pour; the valves close on that same edge.
- All outputs are registered or decoded from registered state only. Inputs never combinationally reach outputs.
- State IDLE:
  - If coffee|soup at an edge: latch the product and go to WAIT_CUP; counter <= CUP_TIMEOUT-1.
  - Product selection: soup if soup=1, else coffee.
  - Both grants high at once: soup wins (matches the coffee-masking rule of the selection logic).
- State WAIT_CUP:
  - cup_present=1 at an edge: go to POUR; counter <= COFFEE_CYCLES-1 or SOUP_CYCLES-1 per the latched product.
  - Else if counter==0: assert error for one cycle and go to REARM.
  - Else: decrement the counter.
- State POUR:
  - The valve for the latched product is 1; the other valve is 0. Valves are never both 1.
  - cup_present=0 at an edge: valve closes that edge, error pulses one cycle, go to REARM, served_count unchanged.
  - Else if counter==0: go to DONE.
  - Else: decrement the counter.
  - With the cup present throughout, the valve is high for exactly COFFEE_CYCLES or SOUP_CYCLES cycles.
- State DONE:
  - Lasts one cycle; done=1 for that cycle.
  - served_count increments on leaving DONE if below 255, else it holds.
  - Next state: REARM.
- State REARM:
  - Stay until coffee=0 and soup=0 at an edge, then go to IDLE.
  - busy=1 throughout.
- Latency:
  - Grant sampled at edge k with cup present: WAIT_CUP from k, valve rises at edge k+1.
  - Valve falls at edge k+1+N; done is high for the cycle after edge k+1+N; IDLE at the earliest at edge k+3+N.
- Grant changes while busy are ignored: the latched product is fixed from IDLE exit until IDLE re-entry.
- error and done are never high in the same cycle.

Decomposition:
- Shared include/package cafe_pkg:
  - state encoding localparams S_IDLE, S_WAIT_CUP, S_POUR, S_DONE, S_REARM (3-bit)
  - product encoding P_COFFEE=0, P_SOUP=1
- One natural sub-module: cafe_timer.
  - CNT_W-bit loadable down-counter with load, load_val and dec inputs and a zero flag.
  - Shared by the cup timeout and the pour duration.
- FSM and output decode stay in cafe_dispenser.

Test Plan:
- Reset mid-pour: rst=1 one cycle at the 4th valve_coffee cycle -> valves 0 on that edge, busy=0, served_count=0, state IDLE.
- Coffee, cup present: coffee=1 for 1 cycle with cup_present=1 -> valve_coffee high exactly 8 cycles, done pulse 1 cycle later, served_count=1, busy falls after grant is 0.
- Simultaneous grants: coffee=1, soup=1 together -> valve_soup high 12 cycles, valve_coffee never 1, served_count=1.
- No cup: soup=1 and cup_present=0 held -> error pulse exactly 16 cycles after acceptance, no valve activity, served_count unchanged.
- Cup removed during pour: cup_present drops at the 5th coffee valve cycle -> valve_coffee falls at that edge, error=1 one cycle, done never asserted, count unchanged.
- Held grant and saturation: coffee held high across one serve -> exactly one dispense until coffee=0 then 1 again; after 256 successful serves, served_count=255.

Source files
------------

// File: rtl/cafe_pkg.sv
// Shared encodings for the cafe dispensing path: FSM states, product codes
// and the saturating serve-counter helper.
package cafe_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_CUP = 3'd1,
        S_POUR     = 3'd2,
        S_DONE     = 3'd3,
        S_REARM    = 3'd4
    } state_t;

    typedef enum logic {
        P_COFFEE = 1'b0,
        P_SOUP   = 1'b1
    } prod_t;

    localparam logic [7:0] SERVED_MAX = 8'd255;

    // Increment a serve count, holding at the top of its range.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == SERVED_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/cafe_timer.sv
// Loadable down-counter shared by the cup timeout and the pour duration.
// Load wins over decrement; decrement stops at zero.
module cafe_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: reload, step down, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register, cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/cafe_dispenser.sv
// Dispensing controller: latches one coffee/soup grant, waits for a cup,
// opens the matching valve for a fixed time, then waits for both grants to
// drop before accepting another request. All outputs are registered.
module cafe_dispenser
    import cafe_pkg::*;
#(
    parameter int COFFEE_CYCLES = 8,
    parameter int SOUP_CYCLES   = 12,
    parameter int CUP_TIMEOUT   = 16,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coffee,
    input  logic       soup,
    input  logic       cup_present,
    output logic       busy,
    output logic       valve_coffee,
    output logic       valve_soup,
    output logic       done,
    output logic       error,
    output logic [7:0] served_count
);

    // Counter reload values: the counter runs N-1 .. 0, i.e. N cycles.
    localparam logic [CNT_W-1:0] CUP_LD    = CNT_W'(CUP_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] COFFEE_LD = CNT_W'(COFFEE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SOUP_LD   = CNT_W'(SOUP_CYCLES - 1);

    state_t     state_q;
    prod_t      prod_q;
    logic [7:0] served_q;
    logic       busy_q;
    logic       vc_q;
    logic       vs_q;
    logic       done_q;
    logic       err_q;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic             tmr_dec;
    logic             tmr_zero;

    cafe_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // Timer control: load on entry to WAIT_CUP / POUR, count down while waiting.
    always_comb begin
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (coffee || soup) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = CUP_LD;
                end
            end
            S_WAIT_CUP: begin
                if (cup_present) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = (prod_q == P_SOUP) ? SOUP_LD : COFFEE_LD;
                end else if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end
            end
            S_POUR: begin
                if (cup_present && !tmr_zero) begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Dispense FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            prod_q   <= P_COFFEE;
            served_q <= 8'd0;
            busy_q   <= 1'b0;
            vc_q     <= 1'b0;
            vs_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (coffee || soup) begin
                        // Soup wins when both grants are high.
                        prod_q  <= soup ? P_SOUP : P_COFFEE;
                        state_q <= S_WAIT_CUP;
                        busy_q  <= 1'b1;
                    end
                end
                S_WAIT_CUP: begin
                    if (cup_present) begin
                        state_q <= S_POUR;
                        vc_q    <= (prod_q == P_COFFEE);
                        vs_q    <= (prod_q == P_SOUP);
                    end else if (tmr_zero) begin
                        err_q   <= 1'b1;
                        state_q <= S_REARM;
                    end
                end
                S_POUR: begin
                    if (!cup_present) begin
                        vc_q    <= 1'b0;
                        vs_q    <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= S_REARM;
                    end else if (tmr_zero) begin
                        vc_q    <= 1'b0;
                        vs_q    <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    served_q <= sat_inc(served_q);
                    state_q  <= S_REARM;
                end
                S_REARM: begin
                    if (!coffee && !soup) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    vc_q    <= 1'b0;
                    vs_q    <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign valve_coffee = vc_q;
    assign valve_soup   = vs_q;
    assign done         = done_q;
    assign error        = err_q;
    assign served_count = served_q;

endmodule

// File: tb/tb_cafe_dispenser.sv
// Testbench for cafe_dispenser: directed scenarios plus randomized
// transactions, each predicted from the request/cup timeline.
module tb_cafe_dispenser;

    localparam int NC = 8;
    localparam int NS = 12;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       coffee;
    logic       soup;
    logic       cup_present;
    logic       busy;
    logic       valve_coffee;
    logic       valve_soup;
    logic       done;
    logic       error;
    logic [7:0] served_count;

    int checks       = 0;
    int failures     = 0;
    int model_served = 0;

    cafe_dispenser #(
        .COFFEE_CYCLES (NC),
        .SOUP_CYCLES   (NS),
        .CUP_TIMEOUT   (TO),
        .CNT_W         (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .coffee       (coffee),
        .soup         (soup),
        .cup_present  (cup_present),
        .busy         (busy),
        .valve_coffee (valve_coffee),
        .valve_soup   (valve_soup),
        .done         (done),
        .error        (error),
        .served_count (served_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are then stable for sampling, inputs set now
    // are taken at the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request from IDLE.
    //   c,s : grants at the acceptance edge (edge offset 0)
    //   j   : first edge offset at which the cup is seen (0 = never arrives)
    //   p   : cup removed at the p-th valve cycle (0 = stays)
    //   h   : grants are nonzero (random pattern) for offsets 0..h-1, then 0
    task automatic txn(input string name, input bit c, input bit s,
                       input int j, input int p, input int h);
        int  n;
        bit  success;
        int  e_off;
        int  vcnt_exp;
        int  idle_exp;
        int  vc_cnt, vs_cnt, first_rise, done_cnt, done_at;
        int  err_cnt, err_at, both, de, idle_at;
        int  v;
        n          = s ? NS : NC;
        success    = 1'b0;
        e_off      = 0;
        vcnt_exp   = 0;
        vc_cnt     = 0;
        vs_cnt     = 0;
        first_rise = -1;
        done_cnt   = 0;
        done_at    = -1;
        err_cnt    = 0;
        err_at     = -1;
        both       = 0;
        de         = 0;
        idle_at    = -1;

        if (j == 0) begin
            e_off = TO;
        end else if (p != 0 && p <= n) begin
            e_off    = j + p;
            vcnt_exp = p;
        end else begin
            success  = 1'b1;
            vcnt_exp = n;
        end
        if (success) idle_exp = (j + n + 2 > h) ? j + n + 2 : h;
        else         idle_exp = (e_off + 1 > h) ? e_off + 1 : h;

        coffee      = c;
        soup        = s;
        cup_present = 1'b0;
        tick();
        check($sformatf("%s.busy_on_accept", name), int'(busy), 1);

        for (int i = 1; i <= idle_exp + 3 && i < 120; i++) begin
            if (i < h) begin
                v      = $urandom_range(1, 3);
                coffee = v[0];
                soup   = v[1];
            end else begin
                coffee = 1'b0;
                soup   = 1'b0;
            end
            cup_present = (j != 0) && (i >= j) && !(p != 0 && p <= n && i >= j + p);
            tick();
            if (valve_coffee) vc_cnt++;
            if (valve_soup)   vs_cnt++;
            if ((valve_coffee || valve_soup) && first_rise < 0) first_rise = i;
            if (valve_coffee && valve_soup) both++;
            if (done && error) de++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            if (error) begin
                err_cnt++;
                if (err_at < 0) err_at = i;
            end
            if (!busy && idle_at < 0) idle_at = i;
        end
        coffee = 1'b0;
        soup   = 1'b0;

        check($sformatf("%s.valve_cycles", name), s ? vs_cnt : vc_cnt, vcnt_exp);
        check($sformatf("%s.other_valve", name), s ? vc_cnt : vs_cnt, 0);
        if (j != 0) check($sformatf("%s.valve_rise", name), first_rise, j);
        check($sformatf("%s.done_count", name), done_cnt, success ? 1 : 0);
        if (success) check($sformatf("%s.done_at", name), done_at, j + n);
        check($sformatf("%s.error_count", name), err_cnt, success ? 0 : 1);
        if (!success) check($sformatf("%s.error_at", name), err_at, e_off);
        check($sformatf("%s.both_valves", name), both, 0);
        check($sformatf("%s.done_and_error", name), de, 0);
        check($sformatf("%s.idle_at", name), idle_at, idle_exp);
        if (success && model_served < 255) model_served++;
        check($sformatf("%s.served", name), int'(served_count), model_served);
    endtask

    initial begin
        int v;
        int jr;
        int pr;
        rst         = 1'b1;
        coffee      = 1'b1;
        soup        = 1'b1;
        cup_present = 1'b1;
        tick();
        tick();
        check("reset.busy", int'(busy), 0);
        check("reset.valve_coffee", int'(valve_coffee), 0);
        check("reset.valve_soup", int'(valve_soup), 0);
        check("reset.done", int'(done), 0);
        check("reset.error", int'(error), 0);
        check("reset.served", int'(served_count), 0);
        rst         = 1'b0;
        coffee      = 1'b0;
        soup        = 1'b0;
        cup_present = 1'b0;
        tick();

        // Directed scenarios
        txn("coffee", 1'b1, 1'b0, 1, 0, 1);
        txn("both", 1'b1, 1'b1, 1, 0, 1);
        txn("nocup", 1'b0, 1'b1, 0, 0, 20);
        txn("pull5", 1'b1, 1'b0, 1, 5, 1);
        txn("pull_last", 1'b0, 1'b1, 1, NS, 1);
        txn("cup_last", 1'b1, 1'b0, TO, 0, 1);
        txn("held", 1'b1, 1'b0, 1, 0, 40);
        txn("after_held", 1'b1, 1'b0, 2, 0, 1);

        // Randomized transactions
        for (int t = 0; t < 24; t++) begin
            v  = $urandom_range(1, 3);
            jr = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, TO);
            pr = ($urandom_range(0, 2) == 0) ? $urandom_range(1, NS + 2) : 0;
            txn($sformatf("rand%0d", t), v[0], v[1], jr, pr, $urandom_range(1, 30));
        end

        // Reset in the middle of a coffee pour
        coffee      = 1'b1;
        soup        = 1'b0;
        cup_present = 1'b0;
        tick();
        coffee      = 1'b0;
        cup_present = 1'b1;
        tick();
        tick();
        tick();
        check("midpour.valve_before_reset", int'(valve_coffee), 1);
        rst = 1'b1;
        tick();
        check("midpour.valve_coffee", int'(valve_coffee), 0);
        check("midpour.valve_soup", int'(valve_soup), 0);
        check("midpour.busy", int'(busy), 0);
        check("midpour.served", int'(served_count), 0);
        check("midpour.done", int'(done), 0);
        rst          = 1'b0;
        cup_present  = 1'b0;
        model_served = 0;
        tick();
        txn("after_reset", 1'b0, 1'b1, 3, 0, 2);

        // Drive the serve count into saturation
        for (int t = 0; t < 256; t++) begin
            txn($sformatf("sat%0d", t), 1'b1, 1'b0, 1, 0, 1);
        end
        check("sat.final_served", int'(served_count), 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
